// File: rtl/comparator_serial.sv
// Serial magnitude comparator: subtracts b from a one W-bit slice per cycle, LSB first,
// then reports lt/eq/gt under the captured signed/unsigned mode plus the full difference.
module comparator_serial #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         lt,
    output logic         eq,
    output logic         gt,
    output logic [N-1:0] diff,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int CHUNKS = N / W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(CHUNKS - 1);

    if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_bad_cfg
        $error("comparator_serial: need N >= 2, 1 <= W <= N and N %% W == 0");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          signed_q, signed_d;
    logic          carry_q, carry_d;
    logic          eq_acc_q, eq_acc_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          lt_q, lt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  a_i_s;
    logic [W-1:0]  b_i_s;
    logic [W:0]    sum_s;
    logic          slice_eq_s;
    logic          msb_s;
    logic          ovf_s;
    logic          lt_u_s;
    logic          lt_s_s;

    function automatic logic [W-1:0] slice_of(input logic [N-1:0] v, input logic [CW-1:0] i);
        return v[int'(i) * W +: W];
    endfunction

    // One slice of a + ~b + cin; the top bit is the carry into the next slice.
    function automatic logic [W:0] slice_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic cin);
        return {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, cin};
    endfunction

    assign in_ready  = (state_q == S_IDLE);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign diff      = diff_q;
    assign out_valid = out_valid_q;

    // Next-state and datapath computation for the current slice.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        carry_d     = carry_q;
        eq_acc_d    = eq_acc_q;
        idx_d       = idx_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        diff_d      = diff_q;
        out_valid_d = out_valid_q;

        a_i_s      = slice_of(a_q, idx_q);
        b_i_s      = slice_of(b_q, idx_q);
        sum_s      = slice_sub(a_i_s, b_i_s, carry_q);
        slice_eq_s = (a_i_s == b_i_s);
        msb_s      = sum_s[W-1];
        // Signed overflow only when operand signs differ and the result sign disagrees with a.
        ovf_s      = (a_q[N-1] != b_q[N-1]) & (msb_s != a_q[N-1]);
        lt_u_s     = ~sum_s[W];
        lt_s_s     = msb_s ^ ovf_s;

        case (state_q)
            S_IDLE: begin
                out_valid_d = 1'b0;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = is_signed;
                    carry_d  = 1'b1;
                    eq_acc_d = 1'b1;
                    idx_d    = {CW{1'b0}};
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_BUSY: begin
                diff_d[int'(idx_q) * W +: W] = sum_s[W-1:0];
                carry_d  = sum_s[W];
                eq_acc_d = eq_acc_q & slice_eq_s;
                if (idx_q == LAST_IDX) begin
                    lt_d        = signed_q ? lt_s_s : lt_u_s;
                    eq_d        = eq_acc_q & slice_eq_s;
                    gt_d        = ~lt_d & ~eq_d;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    idx_d       = idx_q + CW'(1);
                    state_d     = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= {N{1'b0}};
            b_q         <= {N{1'b0}};
            signed_q    <= 1'b0;
            carry_q     <= 1'b1;
            eq_acc_q    <= 1'b1;
            idx_q       <= {CW{1'b0}};
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            diff_q      <= {N{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            carry_q     <= carry_d;
            eq_acc_q    <= eq_acc_d;
            idx_q       <= idx_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            diff_q      <= diff_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench: three comparator_serial instances (W=8, W=32, W=1, all N=32) share stimulus;
// results, latency, backpressure and mid-operation reset are checked against hand-computed values.
module tb_comparator_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        sgn = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    wire  [2:0]  ir;
    wire  [2:0]  ltv;
    wire  [2:0]  eqv;
    wire  [2:0]  gtv;
    wire  [2:0]  ov;
    wire  [31:0] dif [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WG = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
        comparator_serial #(.N(32), .W(WG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .a         (a_in),
            .b         (b_in),
            .is_signed (sgn),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .lt        (ltv[g]),
            .eq        (eqv[g]),
            .gt        (gtv[g]),
            .diff      (dif[g]),
            .out_valid (ov[g]),
            .out_ready (out_ready)
        );
    end

    function automatic int chunks_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ef = {lt, eq, gt}
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb2,
                          input logic ts, input logic [2:0] ef, input logic [31:0] ed,
                          input bit bp);
        int lat [3];
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s in_ready_idle[%0d]", name, g), 64'(ir[g]), 64'd1);
        end
        a_in = ta;
        b_in = tb2;
        sgn  = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = '{0, 0, 0};
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < 3; g++) begin
                if (lat[g] == 0 && ov[g] === 1'b1) lat[g] = cyc;
            end
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s latency[%0d]", name, g), 64'(lat[g]), 64'(chunks_of(g)));
            check($sformatf("%s flags[%0d]", name, g), 64'({ltv[g], eqv[g], gtv[g]}), 64'(ef));
            check($sformatf("%s diff[%0d]", name, g), 64'(dif[g]), 64'(ed));
            check($sformatf("%s in_ready_done[%0d]", name, g), 64'(ir[g]), 64'd0);
        end
        if (bp) begin
            for (int k = 0; k < 6; k++) begin
                a_in = ~a_in;
                b_in = b_in + 32'd3;
                in_valid = ~in_valid;
                @(posedge clk);
                #1;
                check($sformatf("%s bp_flags k%0d", name, k), 64'({ltv[0], eqv[0], gtv[0]}), 64'(ef));
                check($sformatf("%s bp_diff k%0d", name, k), 64'(dif[0]), 64'(ed));
                check($sformatf("%s bp_in_ready k%0d", name, k), 64'(ir[0]), 64'd0);
                check($sformatf("%s bp_out_valid k%0d", name, k), 64'(ov[0]), 64'd1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s out_valid_drop[%0d]", name, g), 64'(ov[g]), 64'd0);
            check($sformatf("%s in_ready_back[%0d]", name, g), 64'(ir[g]), 64'd1);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset out_valid[%0d]", g), 64'(ov[g]), 64'd0);
            check($sformatf("reset flags[%0d]", g), 64'({ltv[g], eqv[g], gtv[g]}), 64'd0);
            check($sformatf("reset diff[%0d]", g), 64'(dif[g]), 64'd0);
        end

        run_op("neg1_vs_1_s", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 32'hFFFF_FFFE, 1'b0);
        run_op("neg1_vs_1_u", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, 32'hFFFF_FFFE, 1'b0);
        run_op("min_vs_max_s", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 32'h0000_0001, 1'b0);
        run_op("min_vs_max_u", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b001, 32'h0000_0001, 1'b0);
        run_op("equal_s", 32'h8000_0000, 32'h8000_0000, 1'b1, 3'b010, 32'h0000_0000, 1'b0);
        run_op("equal_u", 32'h8000_0000, 32'h8000_0000, 1'b0, 3'b010, 32'h0000_0000, 1'b0);
        // Upper slices equal, only the lowest differs: eq must not come from the last slice alone.
        run_op("low_only_u", 32'h0000_0001, 32'h0000_0000, 1'b0, 3'b001, 32'h0000_0001, 1'b0);
        run_op("high_only_u", 32'h0000_0005, 32'h0100_0005, 1'b0, 3'b100, 32'hFF00_0000, 1'b0);
        run_op("backpressure", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'b001, 32'hFFFF_FFFF, 1'b1);

        // Reset while the W=8 instance is working on slice 2.
        a_in = 32'hFFFF_FFFF;
        b_in = 32'h0000_0001;
        sgn  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("midrst out_valid[%0d]", g), 64'(ov[g]), 64'd0);
            check($sformatf("midrst flags[%0d]", g), 64'({ltv[g], eqv[g], gtv[g]}), 64'd0);
            check($sformatf("midrst diff[%0d]", g), 64'(dif[g]), 64'd0);
            check($sformatf("midrst in_ready[%0d]", g), 64'(ir[g]), 64'd1);
        end
        seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (ov !== 3'b000) seen = 1'b1;
        end
        check("midrst dropped_op", 64'(seen), 64'd0);

        run_op("after_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 32'hFFFF_FFFE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
